// File: rtl/rv32i_multicycle_ctrl_if.sv
// rtl/rv32i_multicycle_ctrl_if.sv - control bundle between the multicycle sequencer and its datapath
interface rv32i_multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_taken;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ALU_Op;
    logic       funct7_en;
    logic       pc_src;
    logic       retire;
    logic       illegal;

    modport master (
        input  opcode, funct3, branch_taken, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, ALU_Op, funct7_en, pc_src,
               retire, illegal
    );

    modport slave (
        output opcode, funct3, branch_taken, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, ALU_Op, funct7_en, pc_src,
               retire, illegal
    );
endinterface

// File: rtl/rv32i_multicycle_ctrl.sv
// rtl/rv32i_multicycle_ctrl.sv - Moore main control sequencer for the multicycle RV32I datapath
module rv32i_multicycle_ctrl (
    input  logic                          clk,
    input  logic                          rst_n,
    rv32i_multicycle_ctrl_if.master       ctrl
);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
        S_MEM_RD, S_LOAD_WB, S_MEM_WR, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       funct7_en;
        logic       pc_src;
        logic       retire;
        logic       illegal;
        logic       in_fetch;
        logic       in_mem_wr;
        logic       in_branch;
    } ctl_t;

    state_t state;
    state_t nxt;
    ctl_t   ctl;

    // Output word for a state; registered alongside the state so outputs come straight from flops.
    function automatic ctl_t ctl_for(input state_t s, input logic [2:0] f3);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'd1;
                c.in_fetch  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 2'd2;
                c.alu_src_b = 2'd2;
            end
            S_EXEC_R: begin
                c.alu_src_a = 2'd1;
                c.alu_op    = 2'b10;
                c.funct7_en = 1'b1;
            end
            S_EXEC_I: begin
                c.alu_src_a = 2'd1;
                c.alu_src_b = 2'd2;
                c.alu_op    = 2'b10;
                c.funct7_en = (f3 == 3'b101);
            end
            S_ALU_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 2'd1;
                c.alu_src_b = 2'd2;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_LOAD_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'd1;
                c.retire     = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
                c.in_mem_wr = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 2'd1;
                c.alu_op    = 2'b01;
                c.pc_src    = 1'b1;
                c.retire    = 1'b1;
                c.in_branch = 1'b1;
            end
            S_JAL: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'd2;
                c.pc_src     = 1'b1;
                c.pc_write   = 1'b1;
                c.retire     = 1'b1;
            end
            S_TRAP:  c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            S_RESET:    nxt = S_FETCH;
            S_FETCH:    nxt = ctrl.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ctrl.opcode)
                    7'b0110011:             nxt = S_EXEC_R;
                    7'b0010011:             nxt = S_EXEC_I;
                    7'b0000011, 7'b0100011: nxt = S_MEM_ADDR;
                    7'b1100011:             nxt = S_BRANCH;
                    7'b1101111:             nxt = S_JAL;
                    default:                nxt = S_TRAP;
                endcase
            end
            S_EXEC_R:   nxt = S_ALU_WB;
            S_EXEC_I:   nxt = S_ALU_WB;
            S_ALU_WB:   nxt = S_FETCH;
            S_MEM_ADDR: nxt = ctrl.opcode[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   nxt = ctrl.mem_ready ? S_LOAD_WB : S_MEM_RD;
            S_LOAD_WB:  nxt = S_FETCH;
            S_MEM_WR:   nxt = ctrl.mem_ready ? S_FETCH : S_MEM_WR;
            S_BRANCH:   nxt = S_FETCH;
            S_JAL:      nxt = S_FETCH;
            S_TRAP:     nxt = S_TRAP;
            default:    nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
            ctl   <= '0;
        end else begin
            state <= nxt;
            ctl   <= ctl_for(nxt, ctrl.funct3);
        end
    end

    // Handshake-qualified enables are the only paths from inputs to outputs.
    assign ctrl.pc_write   = ctl.pc_write | (ctl.in_fetch & ctrl.mem_ready)
                           | (ctl.in_branch & ctrl.branch_taken);
    assign ctrl.ir_write   = ctl.in_fetch & ctrl.mem_ready;
    assign ctrl.retire     = ctl.retire | (ctl.in_mem_wr & ctrl.mem_ready);
    assign ctrl.mem_read   = ctl.mem_read;
    assign ctrl.mem_write  = ctl.mem_write;
    assign ctrl.i_or_d     = ctl.i_or_d;
    assign ctrl.reg_write  = ctl.reg_write;
    assign ctrl.mem_to_reg = ctl.mem_to_reg;
    assign ctrl.alu_src_a  = ctl.alu_src_a;
    assign ctrl.alu_src_b  = ctl.alu_src_b;
    assign ctrl.ALU_Op     = ctl.alu_op;
    assign ctrl.funct7_en  = ctl.funct7_en;
    assign ctrl.pc_src     = ctl.pc_src;
    assign ctrl.illegal    = ctl.illegal;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb/tb_rv32i_multicycle_ctrl.sv - bench for rv32i_multicycle_ctrl against a per-instruction cycle schedule model
module tb_rv32i_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv32i_multicycle_ctrl_if bus ();

    rv32i_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus.master)
    );

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        mr;
        logic        bt;
        logic [17:0] exp;
        string       tag;
    } step_t;

    step_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    logic [17:0] obs;
    assign obs = {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.i_or_d,
                  bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.ALU_Op,
                  bus.funct7_en, bus.pc_src, bus.retire, bus.illegal};

    function automatic logic [17:0] v(input logic pcw, irw, mr, mw, iod, rw,
                                      input logic [1:0] m2r, asa, asb, aop,
                                      input logic f7, psrc, ret, ill);
        return {pcw, irw, mr, mw, iod, rw, m2r, asa, asb, aop, f7, psrc, ret, ill};
    endfunction

    task automatic check(input string tag, input logic [17:0] o, input logic [17:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic mr,
                        input logic bt, input logic [17:0] e, input string tag);
        step_t s;
        s.opcode = op; s.funct3 = f3; s.mr = mr; s.bt = bt; s.exp = e; s.tag = tag;
        q.push_back(s);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // kind: 0=R 1=I 2=load 3=store 4=branch 5=jal; one entry per expected cycle
    task automatic gen(input int kind, input logic [2:0] f3, input int wf, input int wm,
                       input logic taken, input int idx);
        logic [6:0] op;
        string t;
        case (kind)
            0: op = 7'h33;
            1: op = 7'h13;
            2: op = 7'h03;
            3: op = 7'h23;
            4: op = 7'h63;
            default: op = 7'h6F;
        endcase
        t = $sformatf("i%0d_k%0d", idx, kind);
        for (int i = 0; i < wf; i++) push(op, f3, 1'b0, rnd(), v(0,0,1,0,0,0,0,0,1,0,0,0,0,0), {t, "_fetch_wait"});
        push(op, f3, 1'b1, rnd(), v(1,1,1,0,0,0,0,0,1,0,0,0,0,0), {t, "_fetch"});
        push(op, f3, rnd(), rnd(), v(0,0,0,0,0,0,0,2,2,0,0,0,0,0), {t, "_decode"});
        case (kind)
            0: begin
                push(op, f3, rnd(), rnd(), v(0,0,0,0,0,0,0,1,0,2,1,0,0,0), {t, "_exec_r"});
                push(op, f3, rnd(), rnd(), v(0,0,0,0,0,1,0,0,0,0,0,0,1,0), {t, "_alu_wb"});
            end
            1: begin
                push(op, f3, rnd(), rnd(), v(0,0,0,0,0,0,0,1,2,2,f3 == 3'd5,0,0,0), {t, "_exec_i"});
                push(op, f3, rnd(), rnd(), v(0,0,0,0,0,1,0,0,0,0,0,0,1,0), {t, "_alu_wb"});
            end
            2: begin
                push(op, f3, rnd(), rnd(), v(0,0,0,0,0,0,0,1,2,0,0,0,0,0), {t, "_mem_addr"});
                for (int i = 0; i < wm; i++) push(op, f3, 1'b0, rnd(), v(0,0,1,0,1,0,0,0,0,0,0,0,0,0), {t, "_rd_wait"});
                push(op, f3, 1'b1, rnd(), v(0,0,1,0,1,0,0,0,0,0,0,0,0,0), {t, "_rd"});
                push(op, f3, rnd(), rnd(), v(0,0,0,0,0,1,1,0,0,0,0,0,1,0), {t, "_load_wb"});
            end
            3: begin
                push(op, f3, rnd(), rnd(), v(0,0,0,0,0,0,0,1,2,0,0,0,0,0), {t, "_mem_addr"});
                for (int i = 0; i < wm; i++) push(op, f3, 1'b0, rnd(), v(0,0,0,1,1,0,0,0,0,0,0,0,0,0), {t, "_wr_wait"});
                push(op, f3, 1'b1, rnd(), v(0,0,0,1,1,0,0,0,0,0,0,0,1,0), {t, "_wr"});
            end
            4: push(op, f3, rnd(), taken, v(taken,0,0,0,0,0,0,1,0,1,0,1,1,0), {t, "_branch"});
            default: push(op, f3, rnd(), rnd(), v(1,0,0,0,0,1,2,0,0,0,0,1,1,0), {t, "_jal"});
        endcase
    endtask

    // Entered #1 after a rising edge; each step drives inputs, checks at the falling edge.
    task automatic run_queue();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            bus.opcode = s.opcode; bus.funct3 = s.funct3;
            bus.mem_ready = s.mr;  bus.branch_taken = s.bt;
            @(negedge clk);
            check(s.tag, obs, s.exp);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.opcode = 7'h0; bus.funct3 = 3'h0; bus.mem_ready = 1'b1; bus.branch_taken = 1'b1;
        #2;
        check("reset_async", obs, 18'h0);
        @(negedge clk); @(negedge clk);
        check("reset_held", obs, 18'h0);
        rst_n = 1'b1;
        #1;
        check("reset_state", obs, 18'h0);
        @(posedge clk);
        #1;

        gen(0, 3'd0, 0, 0, 1'b0, 0);
        gen(1, 3'd0, 0, 0, 1'b0, 1);
        gen(1, 3'd5, 0, 0, 1'b0, 2);
        gen(2, 3'd2, 0, 3, 1'b0, 3);
        gen(4, 3'd0, 0, 0, 1'b0, 4);
        gen(4, 3'd0, 0, 0, 1'b1, 5);
        gen(5, 3'd0, 0, 0, 1'b0, 6);
        gen(3, 3'd2, 1, 2, 1'b0, 7);
        run_queue();

        for (int i = 0; i < 40; i++) begin
            gen($urandom_range(0, 5), 3'($urandom_range(0, 7)), $urandom_range(0, 3),
                $urandom_range(0, 3), rnd(), 100 + i);
            run_queue();
        end

        // Store that is reset while its write request is pending.
        gen(3, 3'd2, 0, 5, 1'b0, 200);
        q = q[0:2];
        run_queue();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("mid_wr_pending", obs, v(0,0,0,1,1,0,0,0,0,0,0,0,0,0));
        bus.mem_ready = 1'b1;
        #1;
        check("mid_wr_ready", obs, v(0,0,0,1,1,0,0,0,0,0,0,0,1,0));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_wr_reset_async", obs, 18'h0);
        @(negedge clk);
        check("mid_wr_reset_held", obs, 18'h0);
        rst_n = 1'b1;
        #1;
        check("mid_wr_reset_state", obs, 18'h0);
        @(posedge clk);
        #1;

        push(7'h73, 3'd0, 1'b1, 1'b0, v(1,1,1,0,0,0,0,0,1,0,0,0,0,0), "trap_fetch");
        push(7'h73, 3'd0, 1'b1, 1'b1, v(0,0,0,0,0,0,0,2,2,0,0,0,0,0), "trap_decode");
        for (int i = 0; i < 10; i++) push(7'h73, 3'd0, rnd(), rnd(), v(0,0,0,0,0,0,0,0,0,0,0,0,0,1), $sformatf("trap_hold%0d", i));
        run_queue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
